id_hazard_ctrl: RTL

ID_HAZARD_CTRL -- requirements
Module: id_hazard_ctrl

---
 rtl/id_hazard_ctrl_pkg.sv | 25 ++
 rtl/id_hazard_ctrl_inst_reg_use.sv | 44 ++++
 rtl/id_hazard_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/id_hazard_ctrl_pkg.sv
// Shared opcode constants, forwarding-select encodings and readiness defaults
// for the ID-stage hazard controller.
package id_hazard_ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam int FWD_SEL_RF     = 0;
  localparam int ALU_READY_DEF  = 1;
  localparam int LOAD_READY_DEF = 2;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } trk_entry_t;

endpackage

// File: rtl/id_hazard_ctrl_inst_reg_use.sv
// Combinational register-usage decoder: which of rd/rs1/rs2 an instruction
// touches, and whether its result comes from memory.
module inst_reg_use
  import id_hazard_ctrl_pkg::*;
(
  input  logic [31:0] i_inst,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic        o_writes_rd,
  output logic        o_reads_rs1,
  output logic        o_reads_rs2,
  output logic        o_is_load
);

  logic [6:0] w_opc;
  logic       w_unused_funct;

  assign w_opc          = i_inst[6:0];
  assign o_rd           = i_inst[11:7];
  assign o_rs1          = i_inst[19:15];
  assign o_rs2          = i_inst[24:20];
  assign w_unused_funct = ^{i_inst[31:25], i_inst[14:12]};

  always_comb begin
    o_writes_rd = 1'b0;
    o_reads_rs1 = 1'b0;
    o_reads_rs2 = 1'b0;
    o_is_load   = 1'b0;
    case (w_opc)
      OPC_OP:     begin o_writes_rd = 1'b1; o_reads_rs1 = 1'b1; o_reads_rs2 = 1'b1; end
      OPC_OPIMM:  begin o_writes_rd = 1'b1; o_reads_rs1 = 1'b1; end
      OPC_LOAD:   begin o_writes_rd = 1'b1; o_reads_rs1 = 1'b1; o_is_load = 1'b1; end
      OPC_STORE:  begin o_reads_rs1 = 1'b1; o_reads_rs2 = 1'b1; end
      OPC_BRANCH: begin o_reads_rs1 = 1'b1; o_reads_rs2 = 1'b1; end
      OPC_JALR:   begin o_writes_rd = 1'b1; o_reads_rs1 = 1'b1; end
      OPC_JAL,
      OPC_LUI,
      OPC_AUIPC:  o_writes_rd = 1'b1;
      default:    ;
    endcase
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage RAW hazard detection and forwarding-select generation, with a
// shadow tracker of destination registers in the post-ID stages.
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int ALU_READY  = ALU_READY_DEF,
  parameter int LOAD_READY = LOAD_READY_DEF,
  parameter int CNT_W      = 32,
  localparam int SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_inst,
  input  logic             id_valid,
  input  logic             backend_stall,
  input  logic             flush,
  output logic             hazard_stall,
  output logic [SEL_W-1:0] fwd_rs1_sel,
  output logic [SEL_W-1:0] fwd_rs2_sel,
  output logic             issue,
  output logic [CNT_W-1:0] stall_count
);

  trk_entry_t       r_trk [DEPTH];
  logic [CNT_W-1:0] r_stall_cnt;

  logic [4:0] w_rd, w_rs1, w_rs2;
  logic       w_writes_rd, w_reads_rs1, w_reads_rs2, w_is_load;
  logic       w_haz1, w_haz2;

  inst_reg_use u_dec (
    .i_inst      (id_inst),
    .o_rd        (w_rd),
    .o_rs1       (w_rs1),
    .o_rs2       (w_rs2),
    .o_writes_rd (w_writes_rd),
    .o_reads_rs1 (w_reads_rs1),
    .o_reads_rs2 (w_reads_rs2),
    .o_is_load   (w_is_load)
  );

  // Scan oldest to youngest so the lowest matching index is the last assignment.
  always_comb begin
    fwd_rs1_sel = SEL_W'(FWD_SEL_RF);
    fwd_rs2_sel = SEL_W'(FWD_SEL_RF);
    w_haz1      = 1'b0;
    w_haz2      = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (r_trk[k].valid && w_reads_rs1 && (w_rs1 != 5'd0) && (r_trk[k].rd == w_rs1)) begin
        if (k >= (r_trk[k].is_load ? LOAD_READY : ALU_READY)) begin
          fwd_rs1_sel = SEL_W'(k + 1);
          w_haz1      = 1'b0;
        end else begin
          fwd_rs1_sel = SEL_W'(FWD_SEL_RF);
          w_haz1      = 1'b1;
        end
      end
      if (r_trk[k].valid && w_reads_rs2 && (w_rs2 != 5'd0) && (r_trk[k].rd == w_rs2)) begin
        if (k >= (r_trk[k].is_load ? LOAD_READY : ALU_READY)) begin
          fwd_rs2_sel = SEL_W'(k + 1);
          w_haz2      = 1'b0;
        end else begin
          fwd_rs2_sel = SEL_W'(FWD_SEL_RF);
          w_haz2      = 1'b1;
        end
      end
    end
  end

  assign hazard_stall = id_valid & ~flush & (w_haz1 | w_haz2);
  assign issue        = id_valid & ~flush & ~hazard_stall & ~backend_stall;
  assign stall_count  = r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) r_trk[k] <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (!backend_stall) begin
        for (int k = DEPTH - 1; k > 0; k--) r_trk[k] <= r_trk[k-1];
        r_trk[0].valid   <= issue & w_writes_rd;
        r_trk[0].rd      <= w_rd;
        r_trk[0].is_load <= w_is_load;
        if (hazard_stall && (r_stall_cnt != {CNT_W{1'b1}}))
          r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule
